// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Types and default constants used by the divider bank and its channels.
//   mode_e        : per-channel output mode (TOGGLE = 50% duty, PULSE = strobe)
//   DEF_N_CH      : default channel count
//   DEF_CNT_W     : default divisor/counter width
//   DEF_RESET_DIV : default divisor loaded into every channel by reset
package clock_divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_RESET_DIV = 0;

endpackage

// File: rtl/clock_divider_channel.sv
// clock_divider_channel
//   One independent divider channel. The counter runs 0..D and wraps; each
//   wrap raises tick for one cycle and either toggles outClk (TOGGLE) or
//   pulses it together with tick (PULSE).
//
//   Reconfiguration request: load is a single-cycle strobe with no ready
//   side. Every cycle load is high, countTo/mode are captured into staging
//   and pending is raised; the latest capture wins. A running channel moves
//   staging into the active divisor/mode only on a wrap edge, so periods are
//   never cut short. A disabled channel applies it on the same edge.
//
// Ports
//   inClk   : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset
//   en      : run enable
//   countTo : divisor to stage
//   mode    : mode to stage
//   load    : stage request strobe
//   outClk  : registered divided output
//   tick    : registered one-cycle wrap strobe
//   pending : a staged divisor/mode awaits application
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             inClk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] countTo,
  input  mode_e            mode,
  input  logic             load,
  output logic             outClk,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] divisor;
  mode_e            curMode;
  logic [CNT_W-1:0] stagedDiv;
  mode_e            stagedMode;

  logic             wrap;
  logic [CNT_W-1:0] applyDiv;
  mode_e            applyMode;

  // count never exceeds divisor (divisor only changes while count is 0),
  // so >= is equivalent to == and also recovers from any corrupt state.
  assign wrap = (count >= divisor);

  // Values the channel adopts when it is allowed to reconfigure: the staged
  // pair if one is waiting, otherwise the current pair.
  always_comb begin
    applyDiv  = divisor;
    applyMode = curMode;
    if (pending) begin
      applyDiv  = stagedDiv;
      applyMode = stagedMode;
    end
  end

  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      divisor    <= RST_DIV;
      curMode    <= MODE_TOGGLE;
      stagedDiv  <= RST_DIV;
      stagedMode <= MODE_TOGGLE;
      pending    <= 1'b0;
      outClk     <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (load) begin
        stagedDiv  <= countTo;
        stagedMode <= mode;
      end

      if (!en) begin
        // Idle: outputs quiet, and any new configuration takes effect now.
        count   <= '0;
        outClk  <= 1'b0;
        tick    <= 1'b0;
        pending <= 1'b0;
        if (load) begin
          divisor <= countTo;
          curMode <= mode;
        end else begin
          divisor <= applyDiv;
          curMode <= applyMode;
        end
      end else if (wrap) begin
        count   <= '0;
        tick    <= 1'b1;
        divisor <= applyDiv;
        curMode <= applyMode;
        // A load on this very edge is not applied here; it waits for the
        // next wrap.
        pending <= load;
        // Entering or staying in PULSE drives the strobe high; leaving PULSE
        // starts the TOGGLE waveform at its high phase.
        if (applyMode == MODE_PULSE || curMode == MODE_PULSE) begin
          outClk <= 1'b1;
        end else begin
          outClk <= ~outClk;
        end
      end else begin
        count   <= count + ONE;
        tick    <= 1'b0;
        pending <= pending | load;
        if (curMode == MODE_PULSE) begin
          outClk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   N_CH independent clock_divider_channel instances sharing one clock and
//   reset. The top level only slices the packed per-channel buses.
//
// Ports
//   inClk   : clock
//   rst     : asynchronous active-high reset
//   en      : per-channel run enable               [N_CH]
//   countTo : per-channel divisor, ch i at [i*CNT_W +: CNT_W]
//   mode    : per-channel mode, 0 TOGGLE / 1 PULSE [N_CH]
//   load    : per-channel stage request strobe     [N_CH]
//   outClk  : per-channel divided output           [N_CH]
//   tick    : per-channel wrap strobe              [N_CH]
//   pending : per-channel staged-value-waiting     [N_CH]
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic                  inClk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*CNT_W-1:0] countTo,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH-1:0]       load,
  output logic [N_CH-1:0]       outClk,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       pending
);

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    clock_divider_channel #(
      .CNT_W    (CNT_W),
      .RESET_DIV(RESET_DIV)
    ) uChannel (
      .inClk  (inClk),
      .rst    (rst),
      .en     (en[i]),
      .countTo(countTo[i*CNT_W +: CNT_W]),
      .mode   (mode_e'(mode[i])),
      .load   (load[i]),
      .outClk (outClk[i]),
      .tick   (tick[i]),
      .pending(pending[i])
    );
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, divisor and counter width in bits (2..32).
REQ-003 Parameter RESET_DIV, default 0, active divisor loaded into every channel by reset.
REQ-004 inClk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  N_CH  per-channel run enable.
REQ-007 countTo  input  N_CH*CNT_W  per-channel divisor; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 mode  input  N_CH  per-channel mode; 0 = TOGGLE (50% duty), 1 = PULSE (one-cycle strobe).
REQ-009 load  input  N_CH  per-channel single-cycle request to stage countTo and mode.
REQ-010 outClk  output  N_CH  registered divided output per channel.
REQ-011 tick  output  N_CH  registered one-cycle strobe marking each wrap.
REQ-012 pending  output  N_CH  high while a staged divisor/mode awaits application.

Function
REQ-013 Each channel SHALL hold count (CNT_W), active divisor D, active mode M, staged divisor, staged mode and pending flag.
REQ-014 Enabled channel, edge with count < D: count SHALL increment by 1; tick next cycle = 0.
REQ-015 Enabled channel, edge with count == D ("wrap edge"): count SHALL return to 0 and tick SHALL be 1 for exactly the following cycle.
REQ-016 TOGGLE mode: outClk SHALL invert on every wrap edge; period = 2*(D+1) inClk cycles, duty 50%.
REQ-017 PULSE mode: outClk SHALL equal tick; period = D+1 cycles, high 1 cycle.
REQ-018 D == 0 SHALL give wrap on every edge: TOGGLE outClk = inClk/2; PULSE outClk and tick continuously high.
REQ-019 load[i] on an edge SHALL capture countTo slice and mode[i] into the staged registers and set pending[i] next cycle.
REQ-020 Enabled channel: staged values SHALL transfer to D/M only on a wrap edge with pending set; pending SHALL clear on that edge; no partial or shortened period SHALL be produced.
REQ-021 load on a wrap edge SHALL NOT affect that wrap; the wrap applies any previously pending value, and the new value becomes pending for the next wrap.
REQ-022 load while pending SHALL overwrite the staged value (last load wins); pending stays set.
REQ-023 Mode change TOGGLE->PULSE applied at wrap SHALL force outClk to follow tick from that edge; PULSE->TOGGLE SHALL start with outClk = 1 (inverted from the previous 0) on that edge.
REQ-024 en[i] low: count SHALL be held at 0, outClk and tick driven 0, and a pending value (or a load in that cycle) SHALL be applied to D/M immediately, clearing pending.
REQ-025 en rising: first wrap edge SHALL occur D+1 edges after the first enabled edge.
REQ-026 Channels SHALL be fully independent; no cross-channel timing interaction.
REQ-027 Counter comparison SHALL be unsigned; count never exceeds D (a D reduced below count is impossible since D changes only at count == 0 transitions).

Reset
REQ-028 rst high SHALL immediately force per channel: count 0, outClk 0, tick 0, pending 0, D = RESET_DIV, M = TOGGLE, staged = RESET_DIV/TOGGLE.
REQ-029 rst asserted mid-period SHALL abandon the period; pending loads SHALL be discarded.
REQ-030 First edge after rst deasserts SHALL behave as REQ-025 with en sampled on that edge.

Structure
REQ-031 Shared package clock_divider_pkg SHALL hold the mode enum (MODE_TOGGLE, MODE_PULSE) and default constants for N_CH, CNT_W, RESET_DIV.
REQ-032 One sub-module clock_divider_channel (single channel, parameter CNT_W) SHALL be instantiated N_CH times via generate; top level only slices buses.

Verification
REQ-033 Reset, en=1, D=3 TOGGLE -> outClk period 8 cycles, high 4, tick every 4 cycles.
REQ-034 D=0 PULSE -> outClk and tick high every cycle; D=0 TOGGLE -> outClk toggles every cycle.
REQ-035 D=9 running, load countTo=4 at count=2 -> pending high, current half-period completes at 10 cycles, then half-periods of 5; pending low after the wrap.
REQ-036 Load 5 then load 7 before wrap -> only 7 applied; load asserted exactly on wrap edge -> applied at following wrap.
REQ-037 en=0 with load countTo=2 mode=PULSE -> pending never observed high, outClk=0; en=1 -> first pulse after 3 cycles.
REQ-038 rst asserted at count=5, D=9, pending set -> all outputs 0, pending 0, D=RESET_DIV; 4 channels with D=1,2,3,4 run concurrently with correct independent periods.
